cntr_rd_arbiter: RTL and testbench

Round-robin arbiter that shares one counter-readout bus among three counter requesters (CNTR1/2/3-style blocks). On a granted request it snapshots the selected counter value and presents it on a valid/ready read port. It holds the snapshot until the consumer accepts it. It sits between the counter bank and the debug/readout logic, so that sampling a counter never tears against its increment.

---
 rtl/cntr_rd_arbiter_if.sv | 39 +++
 rtl/cntr_rd_arbiter.sv | 165 ++++++++++++++++
 tb/tb_cntr_rd_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cntr_rd_arbiter_if.sv
// rtl/cntr_rd_arbiter_if.sv - Bus bundle between the counter requesters/consumer and cntr_rd_arbiter
//
// Signals:
//   REQ[2:0]      per-requester level request, bit i = requester i
//   CNT_IN0..2    counter values of requesters 0..2 (WIDTH bits)
//   RD_READY      consumer accepts RD_DATA
//   GNT[2:0]      one-hot grant, 0 when idle
//   RD_DATA       captured counter snapshot (WIDTH bits)
//   RD_ID[1:0]    index of the granted requester
//   RD_VALID      RD_DATA/RD_ID valid
//   BUSY          arbiter not idle
//   TMO_ERR       one-cycle timeout pulse
// Modports: master = requesters/consumer side, slave = arbiter side.

interface cntr_rd_arbiter_if #(
    parameter int WIDTH = 3
);
    logic [2:0]       REQ;
    logic [WIDTH-1:0] CNT_IN0;
    logic [WIDTH-1:0] CNT_IN1;
    logic [WIDTH-1:0] CNT_IN2;
    logic             RD_READY;
    logic [2:0]       GNT;
    logic [WIDTH-1:0] RD_DATA;
    logic [1:0]       RD_ID;
    logic             RD_VALID;
    logic             BUSY;
    logic             TMO_ERR;

    modport master (
        output REQ, CNT_IN0, CNT_IN1, CNT_IN2, RD_READY,
        input  GNT, RD_DATA, RD_ID, RD_VALID, BUSY, TMO_ERR
    );

    modport slave (
        input  REQ, CNT_IN0, CNT_IN1, CNT_IN2, RD_READY,
        output GNT, RD_DATA, RD_ID, RD_VALID, BUSY, TMO_ERR
    );
endinterface

// File: rtl/cntr_rd_arbiter.sv
// rtl/cntr_rd_arbiter.sv - Round-robin arbiter snapshotting one of three counters onto a valid/ready read port
//
// Ports:
//   CLK    rising-edge clock
//   RST_B  asynchronous active-low reset
//   bus    cntr_rd_arbiter_if.slave (REQ, CNT_IN0..2, RD_READY in; GNT, RD_DATA,
//          RD_ID, RD_VALID, BUSY, TMO_ERR out); all outputs are registered
// Parameters:
//   WIDTH    counter / RD_DATA width
//   TIMEOUT  max unacknowledged RD_VALID cycles (1..255), used with CNTR_RD_TMO_EN
// Optional feature macro: CNTR_RD_TMO_EN (XFER timeout with TMO_ERR pulse).

module cntr_rd_arbiter #(
    parameter int WIDTH   = 3,
    parameter int TIMEOUT = 15
) (
    input logic            CLK,
    input logic            RST_B,
    cntr_rd_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       id_q, id_d;
    logic [1:0]       last_q, last_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] cnt_sel;

`ifdef CNTR_RD_TMO_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_q, wait_d;
    logic       tmo_q, tmo_d;
`endif

    // Search order LAST+1, LAST+2, LAST (mod 3). Walking from lowest to highest
    // priority lets the highest-priority requester overwrite the result.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] win;
        int         c;
        win = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            c = (int'(last) + k) % 3;
            if (req[c]) win = 2'(c);
        end
        return win;
    endfunction

    always_comb begin
        case (id_q)
            2'd1:    cnt_sel = bus.CNT_IN1;
            2'd2:    cnt_sel = bus.CNT_IN2;
            default: cnt_sel = bus.CNT_IN0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        gnt_d     = gnt_q;
        data_d    = data_q;
        id_d      = id_q;
        last_d    = last_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
`ifdef CNTR_RD_TMO_EN
        wait_d    = wait_q;
        tmo_d     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|bus.REQ) begin
                    id_d      = rr_pick(bus.REQ, last_q);
                    gnt_d     = 3'b001 << rr_pick(bus.REQ, last_q);
                    busy_d    = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // The only point where the counter is sampled; later
                // increments cannot disturb the presented value.
                data_d    = cnt_sel;
                valid_d   = 1'b1;
                state_nxt = XFER;
`ifdef CNTR_RD_TMO_EN
                wait_d    = 8'd0;
`endif
            end
            XFER: begin
                // Ready is checked first so a same-edge ready beats the timeout.
                if (bus.RD_READY) begin
                    valid_d   = 1'b0;
                    gnt_d     = 3'b000;
                    busy_d    = 1'b0;
                    last_d    = id_q;
                    state_nxt = IDLE;
                end
`ifdef CNTR_RD_TMO_EN
                else if (wait_q == TMO_LAST) begin
                    valid_d   = 1'b0;
                    gnt_d     = 3'b000;
                    busy_d    = 1'b0;
                    last_d    = id_q;
                    tmo_d     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                gnt_d     = 3'b000;
                valid_d   = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state   <= IDLE;
            gnt_q   <= 3'b000;
            data_q  <= '0;
            id_q    <= 2'd0;
            last_q  <= 2'd2;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef CNTR_RD_TMO_EN
            wait_q  <= 8'd0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            id_q    <= id_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
`ifdef CNTR_RD_TMO_EN
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign bus.GNT      = gnt_q;
    assign bus.RD_DATA  = data_q;
    assign bus.RD_ID    = id_q;
    assign bus.RD_VALID = valid_q;
    assign bus.BUSY     = busy_q;
`ifdef CNTR_RD_TMO_EN
    assign bus.TMO_ERR  = tmo_q;
`else
    assign bus.TMO_ERR  = 1'b0;
`endif

endmodule

// File: tb/tb_cntr_rd_arbiter.sv
// tb/tb_cntr_rd_arbiter.sv - Self-checking bench for cntr_rd_arbiter (directed steps plus randomized traffic)

module tb_cntr_rd_arbiter;
    localparam int WIDTH   = 3;
    localparam int TIMEOUT = 15;

    logic CLK   = 1'b0;
    logic RST_B = 1'b0;

    cntr_rd_arbiter_if #(.WIDTH(WIDTH)) bus ();

    cntr_rd_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .CLK  (CLK),
        .RST_B(RST_B),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: m_age < 0 means no transaction; otherwise it counts
    // cycles since the grant (0 = grant cycle, >= 1 = data presented).
    int m_age, m_last, m_id, m_data, m_tmo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cnt_of(input int id);
        case (id)
            1:       return int'(bus.CNT_IN1);
            2:       return int'(bus.CNT_IN2);
            default: return int'(bus.CNT_IN0);
        endcase
    endfunction

    task automatic model_reset();
        m_age  = -1;
        m_last = 2;
        m_id   = 0;
        m_data = 0;
        m_tmo  = 0;
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_step();
        int c;
        m_tmo = 0;
        if (m_age < 0) begin
            for (int k = 1; k <= 3; k++) begin
                c = (m_last + k) % 3;
                if (bus.REQ[c]) begin
                    m_id  = c;
                    m_age = 0;
                    break;
                end
            end
        end else if (m_age == 0) begin
            m_data = cnt_of(m_id);
            m_age  = 1;
        end else if (bus.RD_READY) begin
            m_last = m_id;
            m_age  = -1;
        end
`ifdef CNTR_RD_TMO_EN
        else if (m_age == TIMEOUT) begin
            m_last = m_id;
            m_age  = -1;
            m_tmo  = 1;
        end
`endif
        else begin
            m_age++;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".GNT"},      32'(bus.GNT),      (m_age >= 0) ? (32'd1 << m_id) : 32'd0);
        check({tag, ".RD_VALID"}, 32'(bus.RD_VALID), (m_age >= 1) ? 32'd1 : 32'd0);
        check({tag, ".BUSY"},     32'(bus.BUSY),     (m_age >= 0) ? 32'd1 : 32'd0);
        check({tag, ".RD_DATA"},  32'(bus.RD_DATA),  32'(m_data));
        check({tag, ".RD_ID"},    32'(bus.RD_ID),    32'(m_id));
        check({tag, ".TMO_ERR"},  32'(bus.TMO_ERR),  32'(m_tmo));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".GNT"},      32'(bus.GNT),      32'd0);
        check({tag, ".RD_VALID"}, 32'(bus.RD_VALID), 32'd0);
        check({tag, ".BUSY"},     32'(bus.BUSY),     32'd0);
        check({tag, ".RD_DATA"},  32'(bus.RD_DATA),  32'd0);
        check({tag, ".RD_ID"},    32'(bus.RD_ID),    32'd0);
        check({tag, ".TMO_ERR"},  32'(bus.TMO_ERR),  32'd0);
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge CLK);
        #1;
        check_model(tag);
    endtask

    initial begin
        int ids[$];
        int vcnt, tcnt;

        bus.REQ      = 3'b000;
        bus.CNT_IN0  = '0;
        bus.CNT_IN1  = '0;
        bus.CNT_IN2  = '0;
        bus.RD_READY = 1'b0;
        model_reset();

        // Reset with arbitrary inputs
        for (int i = 0; i < 3; i++) begin
            bus.REQ      = 3'($urandom);
            bus.RD_READY = 1'($urandom);
            @(posedge CLK);
            #1;
            check_reset_vals("reset");
        end
        RST_B    = 1'b1;
        bus.REQ  = 3'b000;
        cycle("idle");

        // Single request from requester 1
        bus.REQ      = 3'b010;
        bus.CNT_IN1  = 3'd5;
        bus.RD_READY = 1'b1;
        cycle("single_g");
        check("single.gnt_edge1", 32'(bus.GNT), 32'b010);
        bus.REQ = 3'b000;
        cycle("single_v");
        check("single.valid_edge2", 32'(bus.RD_VALID), 32'd1);
        check("single.data_edge2", 32'(bus.RD_DATA), 32'd5);
        check("single.id_edge2", 32'(bus.RD_ID), 32'd1);
        cycle("single_d");
        check("single.gnt_edge3", 32'(bus.GNT), 32'd0);
        check("single.busy_edge3", 32'(bus.BUSY), 32'd0);

        // Backpressure: snapshot must not follow the moving counter
        bus.REQ      = 3'b001;
        bus.CNT_IN0  = 3'd3;
        bus.RD_READY = 1'b0;
        cycle("bp_g");
        bus.REQ = 3'b000;
        cycle("bp_c");
        for (int i = 0; i < 6; i++) begin
            bus.CNT_IN0 = bus.CNT_IN0 + 3'd1;
            cycle("bp_hold");
            check("bp.data_held", 32'(bus.RD_DATA), 32'd3);
            check("bp.gnt_held", 32'(bus.GNT), 32'b001);
        end
        bus.REQ      = 3'b111;
        bus.RD_READY = 1'b1;
        cycle("bp_done");
        cycle("bp_next");
        check("bp.next_gnt", 32'(bus.GNT), 32'b010);
        bus.REQ = 3'b000;
        for (int i = 0; i < 3; i++) cycle("bp_drain");

        // Reset in the middle of a transfer
        bus.REQ      = 3'b100;
        bus.RD_READY = 1'b0;
        cycle("mr_g");
        cycle("mr_c");
        check("mr.valid_before", 32'(bus.RD_VALID), 32'd1);
        #2;
        RST_B = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        model_reset();
        @(posedge CLK);
        #1;
        RST_B = 1'b1;

        // Fairness with all three requesting
        bus.REQ      = 3'b111;
        bus.RD_READY = 1'b1;
        for (int i = 0; i < 18; i++) begin
            cycle("fair");
            if (bus.RD_VALID === 1'b1) ids.push_back(int'(bus.RD_ID));
        end
        check("fair.count", 32'(ids.size()), 32'd6);
        for (int i = 0; i < ids.size() && i < 6; i++)
            check("fair.seq", 32'(ids[i]), 32'(i % 3));

        // Timeout (or indefinite wait when the feature is off)
        bus.REQ      = 3'b100;
        bus.RD_READY = 1'b0;
        cycle("tmo_g");
        bus.REQ = 3'b000;
        vcnt = 0;
        tcnt = 0;
`ifdef CNTR_RD_TMO_EN
        for (int i = 0; i < 20; i++) begin
            cycle("tmo");
            if (bus.RD_VALID === 1'b1) vcnt++;
            if (bus.TMO_ERR === 1'b1) tcnt++;
        end
        check("tmo.valid_cycles", 32'(vcnt), 32'(TIMEOUT));
        check("tmo.pulses", 32'(tcnt), 32'd1);
`else
        for (int i = 0; i < 110; i++) begin
            cycle("notmo");
            if (bus.RD_VALID === 1'b1) vcnt++;
            if (bus.TMO_ERR === 1'b1) tcnt++;
        end
        check("notmo.valid_cycles", 32'(vcnt), 32'd110);
        check("notmo.pulses", 32'(tcnt), 32'd0);
`endif
        bus.RD_READY = 1'b1;
        for (int i = 0; i < 3; i++) cycle("tmo_drain");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.REQ      = 3'($urandom);
            bus.CNT_IN0  = WIDTH'($urandom);
            bus.CNT_IN1  = WIDTH'($urandom);
            bus.CNT_IN2  = WIDTH'($urandom);
            bus.RD_READY = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
